frame_tx_echo: RTL
==================

// Module: frame_tx_echo
// PURPOSE
//  Downstream partner of frame_rx: on each dv_out strobe it snapshots the register file
//  (wr_val) and streams an echo frame (Ethernet hdr + GFAS hdr + Nregs*4 data bytes,
//  zero-padded to 60 B) into the tx mac_fifo over AXI-stream, 8 bits/beat.
//  Gives host-side confirmation of every register write.
// PARAMETERS
//  Nregs      16                 number of 32-bit registers echoed
//  DST_MAC    48'hFFFF_FFFF_FFFF destination MAC, frame bytes 0-5, MSB first
//  SRC_MAC    48'h0200_0000_0001 source MAC, frame bytes 6-11, MSB first
//  ETHERTYPE  16'h88B5           frame bytes 12-13, MSB first
//  GFAS_HDR   48'hFAF3_DEAD_BEEF GFAS header, frame bytes 14-19, MSB first
// PORTS
//  clk             in   1          system clock (frame_rx clock domain)
//  resetn          in   1          asynchronous, active-low reset
//  dv_in           in   1          1-cycle strobe from frame_rx dv_out
//  wr_val          in   Nregs*32   register file from frame_rx, [Nregs-1:0][31:0]
//  tx_fifo_tvalid  out  1          AXI-S valid to tx fifo
//  tx_fifo_tready  in   1          AXI-S ready (= ~fifo_full)
//  tx_fifo_tdata   out  8          AXI-S data byte
//  tx_fifo_tlast   out  1          high on final byte of frame
//  tx_fifo_tuser   out  1          tied 0 (no error)
//  busy            out  1          frame in progress or pending
//  drop_count      out  16         saturating count of dropped dv_in strobes
// BEHAVIOUR
//  Reset (async assert, sync deassert inside): all outputs 0, FSM IDLE, counters 0, pending 0.
//  L = max(60, 20 + 4*Nregs) bytes; byte counter width = clog2(L).
//  FSM: IDLE -> HDR (bytes 0-19) -> DATA (20..20+4*Nregs-1) -> PAD (zeros, only if L>20+4*Nregs)
//       -> IDLE, or -> HDR directly if pending set.
//  Start: dv_in in IDLE loads shadow <= wr_val; first beat valid on next cycle (latency 1).
//  Data order: frame byte 20+4k+b = shadow[k][8b+7:8b] (reg 0 first, little-endian in word).
//  Handshake: beat transfers when tvalid&&tready; once tvalid high, tvalid/tdata/tlast held
//   stable until transfer; tvalid continuous within frame (no bubbles unless tready low).
//  tlast=1 only on byte L-1; tvalid drops the cycle after it transfers unless pending.
//  dv_in while busy and pending=0: pending<=1; the next frame re-snapshots wr_val on the
//   cycle byte L-1 transfers (latest values echoed), HDR starts with no idle beat.
//  dv_in while pending=1: strobe dropped, drop_count+1, saturates at 16'hFFFF.
//  dv_in on same cycle as byte L-1 transfer: treated as pending (back-to-back frame).
//  wr_val changes mid-frame: no effect (shadow used).
//  busy = (state!=IDLE) | pending.
//  Reset mid-frame: stream stops immediately, no tlast; tx fifo sees truncated frame (accepted).
// TESTING
//  1 Nregs=16, wr_val[k]=bytes {4k+4,4k+3,4k+2,4k+1}, one dv_in, tready=1 -> 84 beats,
//    bytes 14-19 = FA F3 DE AD BE EF, byte 20=01, byte 83=40 w/ tlast, 84 consecutive cycles.
//  2 same, tready random 50% -> identical byte sequence; tdata/tvalid stable while stalled.
//  3 Nregs=4 -> 60 beats, bytes 36-59 = 00, tlast only on byte 59.
//  4 dv_in x2 during frame 1 -> frame 2 back-to-back, carries wr_val at frame-1 end;
//    dv_in x3 -> 2 frames, drop_count=1.
//  5 wr_val changed mid-frame -> current frame unchanged; dv_in on last-beat cycle -> next
//    frame starts immediately.
//  6 resetn low at byte 30 -> outputs 0 same cycle; after release, dv_in -> full clean frame.

Source files
------------

// File: rtl/frame_tx_echo_if.sv
// AXI-stream byte channel from the echo generator into the tx mac fifo.
// The master drives the beat and the slave returns tready (= ~fifo_full).
interface frame_tx_echo_if;
   logic       tvalid;
   logic       tready;
   logic [7:0] tdata;
   logic       tlast;
   logic       tuser;

   modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
   modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/frame_tx_echo.sv
// Echo frame generator: each dv_in strobe snapshots the register file and streams
// Ethernet hdr + GFAS hdr + register bytes (zero-padded to 60 B) one byte per beat.
module frame_tx_echo #(
   parameter int          Nregs     = 16,
   parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter logic [47:0] GFAS_HDR  = 48'hFAF3_DEAD_BEEF
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   dv_in,
   input  logic [Nregs-1:0][31:0] wr_val,
   frame_tx_echo_if.master        tx_fifo,
   output logic                   busy,
   output logic [15:0]            drop_count
);
   localparam int DLEN = 20 + 4*Nregs;
   localparam int L    = (DLEN > 60) ? DLEN : 60;
   localparam int CW   = $clog2(L);
   localparam logic [CW-1:0]  LAST_IDX  = CW'(L-1);
   localparam logic [159:0]   HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE, GFAS_HDR};

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_PAD} state_t;

   // Assertion is immediate, release is retimed to clk.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync_q <= '0;
      else         rst_sync_q <= rst_sync_d;
   end

   state_t                 st_q, st_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [Nregs-1:0][31:0] shadow_q, shadow_d;
   logic                   pending_q, pending_d;
   logic [15:0]            drop_q, drop_d;
   logic                   tvalid_q, tvalid_d;
   logic [7:0]             tdata_q, tdata_d;
   logic                   tlast_q, tlast_d;

   // Whole frame image as a byte table, indexed directly by the byte counter.
   logic [L-1:0][7:0] frame_b;

   for (genvar i = 0; i < 20; i++) begin : g_hdr
      assign frame_b[i] = HDR_BYTES[159-8*i -: 8];
   end
   for (genvar k = 0; k < Nregs; k++) begin : g_reg
      for (genvar b = 0; b < 4; b++) begin : g_byte
         assign frame_b[20+4*k+b] = shadow_q[k][8*b +: 8];
      end
   end
   for (genvar p = DLEN; p < L; p++) begin : g_pad
      assign frame_b[p] = 8'h00;
   end

   logic          xfer;
   logic          last_xfer;
   logic [CW-1:0] nxt;

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      drop_d    = drop_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;
      xfer      = tvalid_q & tx_fifo.tready;
      last_xfer = xfer & tlast_q;
      nxt       = cnt_q + CW'(1);

      // Strobes arriving mid-frame: first one is queued, further ones are dropped.
      if (dv_in && st_q != S_IDLE) begin
         if (pending_q) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if ((st_q == S_IDLE && dv_in) || (last_xfer && (pending_q || dv_in))) begin
         st_d      = S_HDR;
         cnt_d     = '0;
         shadow_d  = wr_val;
         pending_d = 1'b0;
         tvalid_d  = 1'b1;
         tdata_d   = DST_MAC[47:40];
         tlast_d   = 1'b0;
      end else if (last_xfer) begin
         st_d     = S_IDLE;
         cnt_d    = '0;
         tvalid_d = 1'b0;
         tdata_d  = 8'h00;
         tlast_d  = 1'b0;
      end else if (xfer) begin
         cnt_d   = nxt;
         tdata_d = frame_b[nxt];
         tlast_d = (nxt == LAST_IDX);
         if (int'(nxt) < 20)        st_d = S_HDR;
         else if (int'(nxt) < DLEN) st_d = S_DATA;
         else                       st_d = S_PAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= S_IDLE;
         cnt_q     <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         drop_q    <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tlast_q   <= tlast_d;
      end
   end

   assign tx_fifo.tvalid = tvalid_q;
   assign tx_fifo.tdata  = tdata_q;
   assign tx_fifo.tlast  = tlast_q;
   assign tx_fifo.tuser  = 1'b0;
   assign busy           = (st_q != S_IDLE) | pending_q;
   assign drop_count     = drop_q;
endmodule
